vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (pixel widths of horizontal regions).
REQ-002 SHALL have parameters: V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (line counts of vertical regions).
REQ-003 SHALL have parameters: HS_POL 0 and VS_POL 0 (asserted sync level; 0 = active-low), CLK_DIV 2 (clk_50 cycles per pixel, >=1), CNT_W 10 (counter width).
REQ-004 SHALL have ports, in order: clk_50 in 1 (single clock); reset_n in 1 (asynchronous, active-low); enable in 1 (run request); pix_ce out 1 (pixel strobe).
REQ-005 SHALL have further ports: hs out 1; vs out 1; h_count out CNT_W; v_count out CNT_W; bright out 1 (active video); line_start out 1; frame_start out 1.

Function
REQ-006 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; region order from count 0: active, front porch, sync, back porch.
REQ-007 SHALL implement FSM states IDLE, RUN, STOPPING.
REQ-008 SHALL go IDLE->RUN on the clock edge where enable=1; counters start at (0,0) and the prescaler at 0.
REQ-009 SHALL go RUN->STOPPING when enable=0, keep generating timing, then go STOPPING->IDLE on the pix_ce where h_count=H_TOTAL-1 and v_count=V_TOTAL-1.
REQ-010 SHALL go STOPPING->RUN when enable=1 again, with no disturbance to counters or syncs.
REQ-011 In IDLE SHALL hold the prescaler and counters at 0, pix_ce=0, hs=!HS_POL, vs=!VS_POL, bright=0, and line_start=frame_start=0.
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 in RUN/STOPPING; pix_ce=1 for one clk_50 cycle when the prescaler=CLK_DIV-1 (pix_ce is constantly 1 in RUN when CLK_DIV=1).
REQ-013 On pix_ce, h_count SHALL increment, wrapping from H_TOTAL-1 to 0; v_count SHALL increment only on that wrap, wrapping from V_TOTAL-1 to 0.
REQ-014 hs SHALL equal HS_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else !HS_POL; vs SHALL decode analogously from v_count.
REQ-015 bright SHALL be 1 iff h_count<H_ACTIVE and v_count<V_ACTIVE, in RUN/STOPPING only.
REQ-016 line_start SHALL equal pix_ce && h_count==0; frame_start SHALL equal line_start && v_count==0.
REQ-017 Counters SHALL wrap exactly at their totals; no count >= H_TOTAL or V_TOTAL is ever output.
REQ-018 Elaboration SHALL fail if 2^CNT_W < max(H_TOTAL,V_TOTAL), if CLK_DIV<1, or if any region width is 0.

Reset
REQ-019 Asserting reset_n=0 SHALL immediately force IDLE and all IDLE output values from REQ-011, including mid-frame and in STOPPING.
REQ-020 After release, the block SHALL stay in IDLE until the first clock edge sampling enable=1.

Configuration
REQ-021 With VGA_SYNC_REG_EN defined, hs, vs, bright, line_start, frame_start, h_count and v_count SHALL all be registered, giving 1 clk_50 of latency with mutual alignment preserved; pix_ce stays unregistered.
REQ-022 Without VGA_SYNC_REG_EN, those outputs SHALL be combinational decodes of the current state and counters, with 0 latency.

Structure
REQ-023 A shared package vga_pkg SHALL hold the default 640x480@60 timing constants, the FSM state typedef, and the total-count helper functions.
REQ-024 The prescaler SHALL be the sub-module vga_pix_ce (ports clk_50, reset_n, run, pix_ce; parameter CLK_DIV).

Verification
REQ-025 Defaults, enable held 1 for 2 frames: hs low for 96 pixels starting at h_count 656, vs low on lines 490-491, 307200 bright pixels per frame, 800x525x2 clk_50 per frame.
REQ-026 enable dropped at (h=100,v=200): timing continues to (799,524), then IDLE with hs=vs=1, bright=0, counters at 0.
REQ-027 enable dropped and then re-raised within the same frame: counters remain continuous and there is no extra frame_start.
REQ-028 reset_n pulsed low at (h=300,v=100) with VGA_SYNC_REG_EN defined: outputs are at IDLE values asynchronously; after release with enable=1, frame_start occurs on the first pix_ce (plus 1 clk_50 of latency).
REQ-029 CLK_DIV=1, HS_POL=1, H=8/2/2/2, V=4/1/1/1: pix_ce is always 1 in RUN, hs is high at h_count 10-11, and the frame lasts 14x7 clk_50 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, the sync
// generator FSM state type, and helpers that derive line/frame totals.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vga_state_e;

    // Total count of one axis: active + front porch + sync + back porch.
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int vga_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// Pixel-clock prescaler: divides clk_50 by CLK_DIV while run is high and
// emits a one-cycle pix_ce on the last prescaler count. Held at 0 when idle.
module vga_pix_ce #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_50,
    input  logic reset_n,
    input  logic run,
    output logic pix_ce
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Strobe on the last count; restart from 0 after each strobe or when stopped.
    always_comb begin
        pix_ce = run && (pre_q == PRE_LAST);
        pre_d  = pre_q;
        if (!run || pix_ce) pre_d = '0;
        else                pre_d = pre_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) pre_q <= '0;
        else          pre_q <= pre_d;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: IDLE/RUN/STOPPING control around h/v pixel counters,
// with hs/vs/bright/line_start/frame_start decoded from the counters.
// Optional macro VGA_SYNC_REG_EN registers all decoded outputs and the
// counter outputs (1 clk_50 latency); pix_ce is never registered.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 10
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             enable,
    output logic             pix_ce,
    output logic             hs,
    output logic             vs,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             bright,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_N  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_N  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Reject configurations the counters or decodes cannot represent.
    if ((64'd1 << CNT_W) < 64'(vga_max(H_TOTAL, V_TOTAL))) begin : g_err_cnt_w
        $error("vga_sync_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_err_clk_div
        $error("vga_sync_gen: CLK_DIV must be >= 1");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_region
        $error("vga_sync_gen: every timing region must be non-empty");
    end

    vga_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             run, end_of_frame;
    logic             hs_d, vs_d, bright_d, line_start_d, frame_start_d;

    assign run = (state_q != ST_IDLE);

    vga_pix_ce #(.CLK_DIV(CLK_DIV)) u_pix_ce (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .run     (run),
        .pix_ce  (pix_ce)
    );

    // Next state and counter advance; counters are parked at 0 while idle.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        end_of_frame = pix_ce && (h_q == H_LAST) && (v_q == V_LAST);
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                // Re-enable wins so a quick toggle never drops the frame.
                if (enable)            state_d = ST_RUN;
                else if (end_of_frame) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (run && pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Sync, blanking and strobe decodes from the current counters.
    always_comb begin
        hs_d          = ~HS_ON;
        vs_d          = ~VS_ON;
        bright_d      = 1'b0;
        line_start_d  = pix_ce && (h_q == '0);
        frame_start_d = line_start_d && (v_q == '0);
        if (run) begin
            if (h_q >= HS_START && h_q < HS_END) hs_d = HS_ON;
            if (v_q >= VS_START && v_q < VS_END) vs_d = VS_ON;
            bright_d = (h_q < H_ACT_N) && (v_q < V_ACT_N);
        end
    end

`ifdef VGA_SYNC_REG_EN
    logic             hs_q, vs_q, bright_q, line_start_q, frame_start_q;
    logic [CNT_W-1:0] h_out_q, v_out_q;

    // Output retiming: everything moves together so alignment is kept.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= ~HS_ON;
            vs_q          <= ~VS_ON;
            bright_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_out_q       <= '0;
            v_out_q       <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            bright_q      <= bright_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_out_q       <= h_q;
            v_out_q       <= v_q;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign bright      = bright_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_count     = h_out_q;
    assign v_count     = v_out_q;
`else
    assign hs          = hs_d;
    assign vs          = vs_d;
    assign bright      = bright_d;
    assign line_start  = line_start_d;
    assign frame_start = frame_start_d;
    assign h_count     = h_q;
    assign v_count     = v_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a cycle model feeds an expected-output queue that
// is compared every clk_50 against the main instance; per-feature tasks add
// timing-count checks. A second, tiny instance covers CLK_DIV=1 / HS_POL=1.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 2;
    localparam int VA = 6,  VF = 2, VSY = 2, VB = 2;
    localparam int DIV = 2, CW = 5;
    localparam int HT = HA + HF + HSY + HB;     // 23
    localparam int VT = VA + VF + VSY + VB;     // 12
    localparam int FRAME = HT * VT * DIV;       // 552 clk_50
    localparam int S_HT = 14, S_VT = 7, S_CW = 4;
`ifdef VGA_SYNC_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    logic          reset_n = 1'b0, enable = 1'b0;
    logic          pix_ce, hs, vs, bright, line_start, frame_start;
    logic [CW-1:0] h_count, v_count;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(DIV), .CNT_W(CW)
    ) u_dut (
        .clk_50(clk_50), .reset_n(reset_n), .enable(enable), .pix_ce(pix_ce),
        .hs(hs), .vs(vs), .h_count(h_count), .v_count(v_count),
        .bright(bright), .line_start(line_start), .frame_start(frame_start)
    );

    logic            reset2_n = 1'b0, en2 = 1'b0;
    logic            s_pce, s_hs, s_vs, s_bright, s_ls, s_fs;
    logic [S_CW-1:0] s_h, s_v;

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .CNT_W(S_CW)
    ) u_small (
        .clk_50(clk_50), .reset_n(reset2_n), .enable(en2), .pix_ce(s_pce),
        .hs(s_hs), .vs(s_vs), .h_count(s_h), .v_count(s_v),
        .bright(s_bright), .line_start(s_ls), .frame_start(s_fs)
    );

    typedef struct packed {
        logic          hs, vs, bright, ls, fs;
        logic [CW-1:0] h, v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;

    // Reference model state: 0 idle, 1 run, 2 stopping.
    int m_st = 0, m_pre = 0, m_h = 0, m_v = 0;
    bit m_pce, m_eof;

    function automatic exp_t model_out();
        exp_t e;
        bit   on, pce;
        on       = (m_st != 0);
        pce      = on && (m_pre == DIV - 1);
        e.hs     = !(on && m_h >= HA + HF && m_h < HA + HF + HSY);
        e.vs     = !(on && m_v >= VA + VF && m_v < VA + VF + VSY);
        e.bright = on && m_h < HA && m_v < VA;
        e.ls     = pce && m_h == 0;
        e.fs     = e.ls && m_v == 0;
        e.h      = CW'(m_h);
        e.v      = CW'(m_v);
        return e;
    endfunction

    // Model step on each clock; reset empties the scoreboard and primes it
    // with idle values to cover the output latency.
    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; m_pre = 0; m_h = 0; m_v = 0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(model_out());
        end else begin
            m_pce = (m_st != 0) && (m_pre == DIV - 1);
            m_eof = m_pce && m_h == HT - 1 && m_v == VT - 1;
            if (m_st == 0) begin
                if (enable) m_st = 1;
            end else begin
                m_pre = m_pce ? 0 : m_pre + 1;
                if (m_pce) begin
                    m_h = m_h + 1;
                    if (m_h == HT) begin
                        m_h = 0;
                        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                    end
                end
                if (m_st == 1 && !enable)      m_st = 2;
                else if (m_st == 2 && enable)  m_st = 1;
                else if (m_st == 2 && m_eof)   m_st = 0;
            end
        end
    end

    // Scoreboard: push this cycle's expectation, pop the one due now.
    always @(negedge clk_50) begin : sb
        exp_t e, got;
        bit   pce_exp;
        if (reset_n) begin
            exp_q.push_back(model_out());
            pce_exp = (m_st != 0) && (m_pre == DIV - 1);
            n_chk++;
            if (pix_ce !== pce_exp)
                $display("FAIL sb_pix_ce t=%0t got=%b exp=%b", $time, pix_ce, pce_exp);
            else n_pass++;
            if (exp_q.size() > LAT) begin
                e   = exp_q.pop_front();
                got = {hs, vs, bright, line_start, frame_start, h_count, v_count};
                n_chk++;
                if (got !== e)
                    $display("FAIL sb_outputs t=%0t got=%h exp=%h", $time, got, e);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk_50);
        n_chk++;
        if ({hs, vs, bright, line_start, frame_start, pix_ce} !== 6'b110000 ||
            h_count !== '0 || v_count !== '0)
            $display("FAIL reset_idle got=%b%b%b%b%b%b h=%0d v=%0d exp=110000 h=0 v=0",
                     hs, vs, bright, line_start, frame_start, pix_ce, h_count, v_count);
        else n_pass++;
        @(posedge clk_50); #2 reset_n = 1'b1;
        repeat (5) @(negedge clk_50);
        n_chk++;
        if ({hs, vs, bright, frame_start, pix_ce} !== 5'b11000 || h_count !== '0)
            $display("FAIL idle_no_enable got=%b%b%b%b%b h=%0d exp=11000 h=0",
                     hs, vs, bright, frame_start, pix_ce, h_count);
        else n_pass++;
    endtask

    task automatic test_frames();
        int t = 0, nb = 0, nhs = 0, nvs = 0, nfs = 0, gap = -1;
        int fh = -1, fv = -1, maxh = 0, maxv = 0;
        @(negedge clk_50); enable = 1'b1;
        while (frame_start !== 1'b1 && t < 100) begin @(negedge clk_50); t++; end
        n_chk++;
        if (t != DIV + LAT) $display("FAIL first_frame_start cycles=%0d exp=%0d", t, DIV + LAT);
        else n_pass++;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk_50);
            if (bright === 1'b1) nb++;
            if (hs === 1'b0) begin nhs++; if (fh < 0) fh = int'(h_count); end
            if (vs === 1'b0) begin nvs++; if (fv < 0) fv = int'(v_count); end
            if (frame_start === 1'b1) begin nfs++; if (c > 0 && gap < 0) gap = c; end
            if (int'(h_count) > maxh) maxh = int'(h_count);
            if (int'(v_count) > maxv) maxv = int'(v_count);
        end
        n_chk++; if (nb != 2 * HA * VA * DIV) $display("FAIL bright_cycles got=%0d exp=%0d", nb, 2 * HA * VA * DIV); else n_pass++;
        n_chk++; if (nhs != 2 * HSY * DIV * VT) $display("FAIL hs_low_cycles got=%0d exp=%0d", nhs, 2 * HSY * DIV * VT); else n_pass++;
        n_chk++; if (nvs != 2 * VSY * HT * DIV) $display("FAIL vs_low_cycles got=%0d exp=%0d", nvs, 2 * VSY * HT * DIV); else n_pass++;
        n_chk++; if (fh != HA + HF) $display("FAIL hs_first_h got=%0d exp=%0d", fh, HA + HF); else n_pass++;
        n_chk++; if (fv != VA + VF) $display("FAIL vs_first_v got=%0d exp=%0d", fv, VA + VF); else n_pass++;
        n_chk++; if (nfs != 2) $display("FAIL frame_start_count got=%0d exp=2", nfs); else n_pass++;
        n_chk++; if (gap != FRAME) $display("FAIL frame_length got=%0d exp=%0d", gap, FRAME); else n_pass++;
        n_chk++; if (maxh != HT - 1 || maxv != VT - 1)
            $display("FAIL count_max got=%0d,%0d exp=%0d,%0d", maxh, maxv, HT - 1, VT - 1);
        else n_pass++;
    endtask

    task automatic test_stop();
        int  t = 0, nfs = 0;
        bit  saw_end = 0, done = 0, pce_seen = 0;
        while (!(h_count == CW'(5) && v_count == CW'(3)) && t < 2 * FRAME) begin
            @(negedge clk_50); t++;
        end
        enable = 1'b0;
        for (int c = 0; c < 2 * FRAME && !done; c++) begin
            @(negedge clk_50);
            if (frame_start === 1'b1) nfs++;
            if (h_count == CW'(HT - 1) && v_count == CW'(VT - 1)) saw_end = 1;
            if (saw_end && h_count == '0 && v_count == '0) done = 1;
        end
        n_chk++; if (!saw_end || !done) $display("FAIL stop_reaches_end saw_end=%0b idle=%0b exp=1,1", saw_end, done); else n_pass++;
        n_chk++; if (nfs != 0) $display("FAIL stop_extra_frame_start got=%0d exp=0", nfs); else n_pass++;
        repeat (2 * DIV + 2) begin @(negedge clk_50); if (pix_ce === 1'b1) pce_seen = 1; end
        n_chk++;
        if ({hs, vs, bright, pce_seen} !== 4'b1100 || h_count !== '0 || v_count !== '0)
            $display("FAIL stop_idle got=%b%b%b%b h=%0d v=%0d exp=1100 h=0 v=0",
                     hs, vs, bright, pce_seen, h_count, v_count);
        else n_pass++;
    endtask

    task automatic test_restart();
        int t = 0, jumps = 0, nfs = 0;
        logic [CW-1:0] ph, pv;
        @(negedge clk_50); enable = 1'b1;
        while (v_count !== CW'(4) && t < 2 * FRAME) begin @(negedge clk_50); t++; end
        ph = h_count; pv = v_count;
        for (int c = 1; c <= 6 * HT * DIV; c++) begin
            @(negedge clk_50);
            if (c == 3)  enable = 1'b0;
            if (c == 10) enable = 1'b1;
            if (frame_start === 1'b1) nfs++;
            if (h_count != ph || v_count != pv) begin
                if (!((h_count == ph + CW'(1) && v_count == pv) ||
                      (ph == CW'(HT - 1) && h_count == '0 && v_count == pv + CW'(1))))
                    jumps++;
            end
            ph = h_count; pv = v_count;
        end
        n_chk++; if (jumps != 0) $display("FAIL restart_continuity jumps=%0d exp=0", jumps); else n_pass++;
        n_chk++; if (nfs != 0) $display("FAIL restart_extra_frame_start got=%0d exp=0", nfs); else n_pass++;
        n_chk++; if (h_count !== '0 || v_count !== CW'(10))
            $display("FAIL restart_position got=%0d,%0d exp=0,10", h_count, v_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t = 0, t_pce = -1, t_fs = -1;
        while (!(h_count == CW'(5) && v_count == CW'(3)) && t < 2 * FRAME) begin
            @(negedge clk_50); t++;
        end
        @(posedge clk_50); #2 reset_n = 1'b0; #1;
        n_chk++;
        if ({hs, vs, bright, line_start, frame_start, pix_ce} !== 6'b110000 ||
            h_count !== '0 || v_count !== '0)
            $display("FAIL reset_async got=%b%b%b%b%b%b h=%0d v=%0d exp=110000 h=0 v=0",
                     hs, vs, bright, line_start, frame_start, pix_ce, h_count, v_count);
        else n_pass++;
        repeat (2) @(negedge clk_50);
        @(posedge clk_50); #2 reset_n = 1'b1;
        for (int c = 1; c <= 20 && t_fs < 0; c++) begin
            @(negedge clk_50);
            if (pix_ce === 1'b1 && t_pce < 0) t_pce = c;
            if (frame_start === 1'b1) t_fs = c;
        end
        n_chk++; if (t_pce != DIV + 1) $display("FAIL reset_first_pix_ce got=%0d exp=%0d", t_pce, DIV + 1); else n_pass++;
        n_chk++; if (t_fs != DIV + 1 + LAT) $display("FAIL reset_first_frame_start got=%0d exp=%0d", t_fs, DIV + 1 + LAT); else n_pass++;
        // Reset while stopping.
        repeat (7) @(negedge clk_50);
        enable = 1'b0;
        repeat (5) @(negedge clk_50);
        @(posedge clk_50); #3 reset_n = 1'b0; #1;
        n_chk++;
        if ({hs, vs, bright, frame_start, pix_ce} !== 5'b11000 || h_count !== '0)
            $display("FAIL reset_in_stopping got=%b%b%b%b%b h=%0d exp=11000 h=0",
                     hs, vs, bright, frame_start, pix_ce, h_count);
        else n_pass++;
        @(negedge clk_50); reset_n = 1'b1;
    endtask

    task automatic test_small();
        int t = 0, npce = 0, nhs = 0, gap = -1, fh = -1, maxh = 0, maxv = 0;
        @(posedge clk_50); #2 reset2_n = 1'b1;
        repeat (3) @(negedge clk_50);
        n_chk++;
        if ({s_pce, s_hs, s_vs, s_bright} !== 4'b0010)
            $display("FAIL small_idle got=%b%b%b%b exp=0010", s_pce, s_hs, s_vs, s_bright);
        else n_pass++;
        en2 = 1'b1;
        while (s_fs !== 1'b1 && t < 50) begin @(negedge clk_50); t++; end
        n_chk++; if (t != 1 + LAT) $display("FAIL small_first_frame_start got=%0d exp=%0d", t, 1 + LAT); else n_pass++;
        for (int c = 0; c < 2 * S_HT * S_VT; c++) begin
            if (c > 0) @(negedge clk_50);
            if (s_pce === 1'b1) npce++;
            if (s_hs === 1'b1) begin nhs++; if (fh < 0) fh = int'(s_h); end
            if (s_fs === 1'b1 && c > 0 && gap < 0) gap = c;
            if (int'(s_h) > maxh) maxh = int'(s_h);
            if (int'(s_v) > maxv) maxv = int'(s_v);
        end
        n_chk++; if (npce != 2 * S_HT * S_VT) $display("FAIL small_pix_ce_always got=%0d exp=%0d", npce, 2 * S_HT * S_VT); else n_pass++;
        n_chk++; if (nhs != 2 * 2 * S_VT) $display("FAIL small_hs_high_cycles got=%0d exp=%0d", nhs, 4 * S_VT); else n_pass++;
        n_chk++; if (fh != 10) $display("FAIL small_hs_first_h got=%0d exp=10", fh); else n_pass++;
        n_chk++; if (gap != S_HT * S_VT) $display("FAIL small_frame_length got=%0d exp=%0d", gap, S_HT * S_VT); else n_pass++;
        n_chk++; if (maxh != S_HT - 1 || maxv != S_VT - 1)
            $display("FAIL small_count_max got=%0d,%0d exp=%0d,%0d", maxh, maxv, S_HT - 1, S_VT - 1);
        else n_pass++;
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_stop();
        test_restart();
        test_reset_mid();
        test_small();
        repeat (3) @(negedge clk_50);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
